row_strobe_decoder: RTL and testbench



---
 rtl/tetris_pkg.sv | 18 +
 rtl/onehot_decoder.sv | 17 +
 rtl/row_strobe_decoder.sv | 89 ++++++++
 tb/tb_row_strobe_decoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared mode constants and playfield row-decoder defaults
package tetris_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_SEL_W = 3;
  localparam int DEF_ROWS  = 8;
  localparam int DEF_DWELL = 4;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational binary to one-hot decoder with enable
module onehot_decoder
  import tetris_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [SEL_W-1:0]      in,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/row_strobe_decoder.sv
// rtl/row_strobe_decoder.sv - registered row decoder with autonomous timed scan
module row_strobe_decoder
  import tetris_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int ROWS  = DEF_ROWS,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap,
  output logic                  err
);

  localparam int N  = 1 << SEL_W;
  localparam int DW = cnt_w(DWELL);
  localparam logic [SEL_W-1:0] ROW_LAST = SEL_W'(ROWS - 1);
  localparam logic [DW-1:0]    D_LAST   = DW'(DWELL - 1);
  localparam logic [SEL_W:0]   ROWS_V   = (SEL_W + 1)'(ROWS);

  logic [SEL_W-1:0] r, r_eff, dec_in;
  logic [DW-1:0]    d, d_eff;
  logic             mode_q, mode_chg, is_scan, in_range, last_row, last_dwell;
  logic [N-1:0]     dec_out;

  // A mode change restarts the scan before the counters are consumed this cycle.
  always_comb begin
    is_scan    = (mode == MODE_SCAN);
    mode_chg   = (mode != mode_q);
    r_eff      = mode_chg ? '0 : r;
    d_eff      = mode_chg ? '0 : d;
    in_range   = ({1'b0, sel} < ROWS_V);
    last_row   = (r_eff == ROW_LAST);
    last_dwell = (d_eff == D_LAST);
    dec_in     = is_scan ? r_eff : sel;
  end

  onehot_decoder #(.SEL_W(SEL_W)) u_dec (
    .in  (dec_in),
    .en  (is_scan || in_range),
    .out (dec_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
      r      <= '0;
      d      <= '0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode;
      if (!en) begin
        out  <= '0;
        wrap <= 1'b0;
        err  <= 1'b0;
      end else if (!is_scan) begin
        out  <= dec_out;
        idx  <= sel;
        err  <= ~in_range;
        wrap <= 1'b0;
        if (mode_chg) begin
          r <= '0;
          d <= '0;
        end
      end else begin
        out  <= dec_out;
        idx  <= r_eff;
        err  <= 1'b0;
        wrap <= last_row && last_dwell;
        if (last_dwell) begin
          d <= '0;
          r <= last_row ? '0 : r_eff + SEL_W'(1);
        end else begin
          d <= d_eff + DW'(1);
          r <= r_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_row_strobe_decoder.sv
// tb/tb_row_strobe_decoder.sv - self-checking bench for row_strobe_decoder
module tb_row_strobe_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [2:0][7:0] o_out;
  logic [2:0][2:0] o_idx;
  logic [2:0]      o_wrap;
  logic [2:0]      o_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance geometry: a = 5 rows/dwell 2, b = 8 rows/dwell 3, c = 1 row/dwell 1.
  int rows_p  [3] = '{5, 8, 1};
  int dwell_p [3] = '{2, 3, 1};

  // Reference state: enabled scan cycles since the scan (re)started.
  int         k [3];
  logic [2:0] exp_idx [3];
  logic       pm;

  always #5 clk = ~clk;

  row_strobe_decoder #(.SEL_W(3), .ROWS(5), .DWELL(2)) u_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(o_out[0]), .idx(o_idx[0]), .wrap(o_wrap[0]), .err(o_err[0])
  );

  row_strobe_decoder #(.SEL_W(3), .ROWS(8), .DWELL(3)) u_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(o_out[1]), .idx(o_idx[1]), .wrap(o_wrap[1]), .err(o_err[1])
  );

  row_strobe_decoder #(.SEL_W(3), .ROWS(1), .DWELL(1)) u_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(o_out[2]), .idx(o_idx[2]), .wrap(o_wrap[2]), .err(o_err[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then compare every instance with the reference.
  task automatic step(input logic rs, input logic e, input logic m, input logic [2:0] s);
    logic       chg;
    logic [7:0] eo;
    logic [2:0] ei;
    logic       ew, ee;
    int         row, frame;
    reset = rs; en = e; mode = m; sel = s;
    @(posedge clk);
    #1;
    chg = (m != pm);
    for (int i = 0; i < 3; i++) begin
      frame = rows_p[i] * dwell_p[i];
      if (rs) begin
        eo = 8'h00; ei = 3'd0; ew = 1'b0; ee = 1'b0; k[i] = 0;
      end else if (!e) begin
        eo = 8'h00; ei = exp_idx[i]; ew = 1'b0; ee = 1'b0;
      end else if (!m) begin
        if (chg) k[i] = 0;
        ee = (int'(s) >= rows_p[i]);
        eo = ee ? 8'h00 : 8'(1 << s);
        ei = s;
        ew = 1'b0;
      end else begin
        if (chg) k[i] = 0;
        row = (k[i] / dwell_p[i]) % rows_p[i];
        eo  = 8'(1 << row);
        ei  = 3'(row);
        ee  = 1'b0;
        ew  = ((k[i] % frame) == frame - 1);
        k[i]++;
      end
      exp_idx[i] = ei;
      chk($sformatf("out[%0d]", i),  32'(o_out[i]),  32'(eo));
      chk($sformatf("idx[%0d]", i),  32'(o_idx[i]),  32'(ei));
      chk($sformatf("wrap[%0d]", i), 32'(o_wrap[i]), 32'(ew));
      chk($sformatf("err[%0d]", i),  32'(o_err[i]),  32'(ee));
    end
    pm = rs ? 1'b0 : m;
  endtask

  initial begin
    logic [7:0] sweep_out [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00};
    logic       sweep_err [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic [2:0] scan_idx [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    logic       m_r;
    pm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k[i] = 0;
      exp_idx[i] = 3'd0;
    end

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_out", 32'(o_out[1]), 32'h0);

    // Reset in the middle of a scan, then release straight into scan.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("midscan_rst_out", 32'(o_out[1]), 32'h0);
    chk("midscan_rst_idx", 32'(o_idx[1]), 32'h0);
    step(0, 1, 1, 0);
    chk("rst_release_out", 32'(o_out[1]), 32'h01);

    // Direct sweep across in-range and out-of-range selects.
    for (int s = 0; s < 8; s++) begin
      step(0, 1, 0, 3'(s));
      chk($sformatf("sweep_out%0d", s), 32'(o_out[0]), 32'(sweep_out[s]));
      chk($sformatf("sweep_err%0d", s), 32'(o_err[0]), 32'(sweep_err[s]));
    end

    // Scan order, wrap position and the degenerate single-row instance.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0);
      if (i < 11) chk($sformatf("scan_idx%0d", i), 32'(o_idx[0]), 32'(scan_idx[i]));
      chk($sformatf("scan_wrap%0d", i), 32'(o_wrap[0]), 32'((i == 9) || (i == 19)));
      chk($sformatf("degen_out%0d", i), 32'(o_out[2]), 32'h01);
      chk($sformatf("degen_wrap%0d", i), 32'(o_wrap[2]), 32'h1);
    end

    // Enable pause during row 2's second dwell cycle.
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
    chk("pause_pre_idx", 32'(o_idx[1]), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk($sformatf("pause_out%0d", i), 32'(o_out[1]), 32'h0);
    end
    step(0, 1, 1, 0);
    chk("resume_out0", 32'(o_out[1]), 32'h04);
    step(0, 1, 1, 0);
    chk("resume_out1", 32'(o_out[1]), 32'h04);
    step(0, 1, 1, 0);
    chk("resume_out2", 32'(o_out[1]), 32'h08);

    // Brief switch to direct then back to scan restarts at row 0.
    step(0, 1, 0, 6);
    chk("toggle_direct", 32'(o_out[1]), 32'h40);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0);
      chk($sformatf("toggle_scan%0d", i), 32'(o_out[1]), (i < 3) ? 32'h01 : 32'h02);
    end

    // Randomized traffic against the reference.
    m_r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) m_r = ~m_r;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), m_r,
           3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
